// File: rtl/blit_fill.sv
// Rectangle fill engine: writes cmd_color over a rectangle of the 8bpp framebuffer as masked 32-bit words.
// Optional macro BLIT_CLIP_EN clips rectangles to the 640x480 screen; without it the caller guarantees bounds.
module blit_fill #(
    parameter logic [25:0] FB_BASE   = 26'h3f80000,
    parameter int unsigned FB_STRIDE = 640
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_width,
    input  logic [9:0]  cmd_height,
    input  logic [7:0]  cmd_color,
    output logic        busy,
    output logic        done,
    output logic        blit_request,
    output logic [25:0] blit_address,
    output logic [31:0] blit_wdata,
    output logic [3:0]  blit_wmask,
    input  logic        blit_ack
);
    localparam int unsigned AW   = 26;
    localparam int unsigned CW   = 10;
    localparam int unsigned EW   = 11;  // x+w and y+h reach 2046
    localparam int unsigned COLW = 9;   // word column of an 11-bit pixel coordinate
`ifdef BLIT_CLIP_EN
    localparam logic [EW-1:0] FB_W = EW'(640);
    localparam logic [EW-1:0] FB_H = EW'(480);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_NEXT_ROW,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   w_q, w_d;
    logic [CW-1:0]   h_q, h_d;
    logic [EW-1:0]   y_q, y_d;
    logic [EW-1:0]   x_end_q, x_end_d;
    logic [EW-1:0]   y_end_q, y_end_d;
    logic [7:0]      color_q, color_d;
    logic [AW-1:0]   row_addr_q, row_addr_d;
    logic [COLW-1:0] col_q, col_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;

    logic [EW-1:0]   x_sum_c, y_sum_c, x_end_c, y_end_c;
    logic [AW-1:0]   y_off_c, row_start_c;
    logic            empty_c;
    logic [COLW-1:0] first_col_c, last_col_c;

    // Byte enables for one word: 'first' trims below lo, 'last' trims above hi.
    function automatic logic [3:0] word_mask(input logic first, input logic last,
                                             input logic [1:0] lo, input logic [1:0] hi);
        logic [3:0] m;
        m = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            if (first && (2'(n) < lo)) m[n] = 1'b0;
            if (last && (2'(n) > hi))  m[n] = 1'b0;
        end
        return m;
    endfunction

    // Rectangle extents and row start address, consumed in SETUP.
    always_comb begin
        x_sum_c = EW'(x_q) + EW'(w_q);
        y_sum_c = y_q + EW'(h_q);
`ifdef BLIT_CLIP_EN
        empty_c = (w_q == '0) || (h_q == '0) || (EW'(x_q) >= FB_W) || (y_q >= FB_H);
        x_end_c = ((x_sum_c > FB_W) ? FB_W : x_sum_c) - EW'(1);
        y_end_c = ((y_sum_c > FB_H) ? FB_H : y_sum_c) - EW'(1);
`else
        empty_c = (w_q == '0) || (h_q == '0);
        x_end_c = x_sum_c - EW'(1);
        y_end_c = y_sum_c - EW'(1);
`endif
        if (FB_STRIDE == 640) begin
            y_off_c = (AW'(y_q) << 9) + (AW'(y_q) << 7);
        end else begin
            y_off_c = AW'(y_q) * AW'(FB_STRIDE);
        end
        row_start_c = FB_BASE + y_off_c + AW'(x_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        w_d        = w_q;
        h_d        = h_q;
        y_d        = y_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        color_d    = color_q;
        row_addr_d = row_addr_q;
        col_d      = col_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        first_col_c = COLW'(x_q[CW-1:2]);
        last_col_c  = x_end_q[EW-1:2];

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    x_d     = cmd_x;
                    y_d     = EW'(cmd_y);
                    w_d     = cmd_width;
                    h_d     = cmd_height;
                    color_d = cmd_color;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                x_end_d    = x_end_c;
                y_end_d    = y_end_c;
                row_addr_d = row_start_c;
                wdata_d    = {4{color_q}};
                if (empty_c) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                    req_d   = 1'b1;
                    col_d   = first_col_c;
                    addr_d  = {row_start_c[AW-1:2], 2'b00};
                    wmask_d = word_mask(1'b1, first_col_c == x_end_c[EW-1:2],
                                        row_start_c[1:0], x_end_c[1:0]);
                end
            end
            ST_WRITE: begin
                if (req_q && blit_ack) begin
                    if (col_q != last_col_c) begin
                        // Next word of the row goes out on the very next cycle.
                        col_d   = col_q + COLW'(1);
                        addr_d  = addr_q + AW'(4);
                        wmask_d = word_mask(1'b0, (col_q + COLW'(1)) == last_col_c,
                                            2'b00, x_end_q[1:0]);
                    end else begin
                        req_d   = 1'b0;
                        state_d = (y_q != y_end_q) ? ST_NEXT_ROW : ST_DONE;
                    end
                end
            end
            ST_NEXT_ROW: begin
                row_addr_d = row_addr_q + AW'(FB_STRIDE);
                y_d        = y_q + EW'(1);
                col_d      = first_col_c;
                req_d      = 1'b1;
                state_d    = ST_WRITE;
                addr_d     = {row_addr_d[AW-1:2], 2'b00};
                wmask_d    = word_mask(1'b1, first_col_c == last_col_c,
                                       row_addr_d[1:0], x_end_q[1:0]);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            color_q    <= '0;
            row_addr_q <= '0;
            col_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= FB_BASE;
            wdata_q    <= '0;
            wmask_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            w_q        <= w_d;
            h_q        <= h_d;
            y_q        <= y_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            color_q    <= color_d;
            row_addr_q <= row_addr_d;
            col_q      <= col_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign blit_request = req_q;
    assign blit_address = addr_q;
    assign blit_wdata   = wdata_q;
    assign blit_wmask   = wmask_q;

endmodule

// File: tb/tb_blit_fill.sv
// Self-checking bench for blit_fill: pixel-level reference model, random fills and random ack timing.
module tb_blit_fill;
    localparam logic [25:0] BASE   = 26'h3f80000;
    localparam int          STRIDE = 640;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x, cmd_y, cmd_width, cmd_height;
    logic [7:0]  cmd_color;
    logic        busy, done, blit_request;
    logic [25:0] blit_address;
    logic [31:0] blit_wdata;
    logic [3:0]  blit_wmask;
    logic        blit_ack;

    blit_fill dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_color(cmd_color), .busy(busy), .done(done),
        .blit_request(blit_request), .blit_address(blit_address),
        .blit_wdata(blit_wdata), .blit_wmask(blit_wmask), .blit_ack(blit_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [25:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  exp_rows, n_cycles, hold_err;
    bit  timed_out, busy_ok, ready_after;
    int  errors = 0;
    int  checks = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: paint every pixel, group byte addresses into words in row order.
    task automatic model_fill(input int x, input int y, input int w, input int h, input logic [7:0] color);
        int xe, ye, a, cur;
        logic [3:0] m;
        wr_t e;
        xe = x + w;
        ye = y + h;
`ifdef BLIT_CLIP_EN
        if (xe > 640) xe = 640;
        if (ye > 480) ye = 480;
`endif
        exp_q.delete();
        exp_rows = 0;
        for (int r = y; r < ye; r++) begin
            cur = -1;
            m = 4'b0000;
            for (int px = x; px < xe; px++) begin
                a = int'(BASE) + r * STRIDE + px;
                if ((a & ~3) != cur) begin
                    if (cur >= 0) begin
                        e.addr = 26'(cur); e.mask = m; e.data = {4{color}};
                        exp_q.push_back(e);
                    end
                    cur = a & ~3;
                    m = 4'b0000;
                end
                m[a[1:0]] = 1'b1;
            end
            if (cur >= 0) begin
                e.addr = 26'(cur); e.mask = m; e.data = {4{color}};
                exp_q.push_back(e);
                exp_rows++;
            end
        end
    endtask

    // Issue one command and act as the arbiter until done; records acked words and handshake health.
    task automatic do_fill(input int x, input int y, input int w, input int h,
                           input logic [7:0] color, input int ack_pct, input bit junk);
        bit  pend, ack;
        wr_t prev, cur;
        int  guard;
        obs_q.delete();
        n_cycles = 0; hold_err = 0; timed_out = 0; busy_ok = 1; ready_after = 0;
        pend = 0; prev = '0;
        guard = 0;
        while (!cmd_ready && guard < 50) begin tick(); guard++; end
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_width = 10'(w); cmd_height = 10'(h);
        cmd_color = color; cmd_valid = 1'b1;
        tick();
        cmd_valid = junk;
        while (!done) begin
            n_cycles++;
            if (n_cycles > 3000) begin timed_out = 1; break; end
            if (!busy) busy_ok = 0;
            cur = {blit_address, blit_wmask, blit_wdata};
            if (pend && (!blit_request || cur !== prev)) hold_err++;
            if (junk) begin
                cmd_x = 10'($urandom); cmd_y = 10'($urandom);
                cmd_width = 10'($urandom); cmd_height = 10'($urandom);
                cmd_color = 8'($urandom);
            end
            if (blit_request) begin
                ack = ($urandom_range(0, 99) < ack_pct);
                if (ack) obs_q.push_back(cur);
                pend = !ack;
                prev = cur;
            end else begin
                ack = ($urandom_range(0, 3) == 0);  // stray ack, must be ignored
                pend = 0;
            end
            blit_ack = ack;
            tick();
            blit_ack = 1'b0;
        end
        cmd_valid = 1'b0;
        if (timed_out) begin
            $display("FAIL fill timeout: no done within 3000 cycles (x=%0d y=%0d w=%0d h=%0d)", x, y, w, h);
            reset = 1'b1; tick(); reset = 1'b0;
        end else begin
            tick();
            ready_after = cmd_ready && !done && !busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({cmd_ready, busy, done, blit_request} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got ready/busy/done/req=%b, want 1000", {cmd_ready, busy, done, blit_request});
        end
        checks++;
        if (blit_address !== BASE || blit_wmask !== 4'b0 || blit_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h mask=%b data=%h, want %h 0000 00000000", blit_address, blit_wmask, blit_wdata, BASE);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_scenarios();
        logic [25:0] s3_addr [6];
        logic [3:0]  s3_mask [6];
        s3_addr = '{26'h3f80280, 26'h3f80284, 26'h3f80288, 26'h3f80500, 26'h3f80504, 26'h3f80508};
        s3_mask = '{4'b1000, 4'b1111, 4'b0001, 4'b1000, 4'b1111, 4'b0001};
        // single full word
        do_fill(0, 0, 4, 1, 8'h5A, 100, 1'b0);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {26'h3f80000, 4'b1111, 32'h5A5A5A5A}) begin
            errors++;
            $display("FAIL s1_word: got %0d words first=%h, want 1 word %h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : '0, {26'h3f80000, 4'b1111, 32'h5A5A5A5A});
        end
        checks++;
        if (timed_out || !ready_after || n_cycles != 2) begin
            errors++;
            $display("FAIL s1_timing: got timeout=%0d ready_after=%0d cycles=%0d, want 0 1 2", timed_out, ready_after, n_cycles);
        end
        // partial word
        do_fill(5, 2, 2, 1, 8'h11, 100, 1'b0);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].addr !== 26'h3f80504 || obs_q[0].mask !== 4'b0110) begin
            errors++;
            $display("FAIL s2_word: got %0d words addr=%h mask=%b, want 1 word 3f80504 0110", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].addr : 26'h0, (obs_q.size() > 0) ? obs_q[0].mask : 4'h0);
        end
        // two rows of three words, ack every cycle
        do_fill(3, 1, 6, 2, 8'hA7, 100, 1'b0);
        checks++;
        if (obs_q.size() != 6 || n_cycles != 8) begin
            errors++;
            $display("FAIL s3_count: got %0d words in %0d cycles, want 6 in 8", obs_q.size(), n_cycles);
        end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== s3_addr[i] || obs_q[i].mask !== s3_mask[i] || obs_q[i].data !== 32'hA7A7A7A7) begin
                errors++;
                $display("FAIL s3_word[%0d]: got addr=%h mask=%b data=%h, want %h %b a7a7a7a7", i,
                         obs_q[i].addr, obs_q[i].mask, obs_q[i].data, s3_addr[i], s3_mask[i]);
            end
        end
        // empty command
        do_fill(10, 10, 0, 3, 8'hFF, 100, 1'b0);
        checks++;
        if (obs_q.size() != 0 || n_cycles != 1 || timed_out || !ready_after) begin
            errors++;
            $display("FAIL s4_empty: got %0d words cycles=%0d timeout=%0d ready_after=%0d, want 0 1 0 1",
                     obs_q.size(), n_cycles, timed_out, ready_after);
        end
    endtask

    task automatic rand_cmd(output int x, output int y, output int w, output int h);
        int wmax, hmax;
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
        wmax = (640 - x < 40) ? 640 - x : 40;
        hmax = (480 - y < 4) ? 480 - y : 4;
        w = int'($urandom_range(1, wmax));
        h = int'($urandom_range(1, hmax));
        if ($urandom_range(0, 9) == 0) w = 0;
        if ($urandom_range(0, 9) == 0) h = 0;
    endtask

    task automatic test_random();
        int x, y, w, h;
        logic [7:0] c;
        for (int t = 0; t < 25; t++) begin
            rand_cmd(x, y, w, h);
            c = 8'($urandom);
            model_fill(x, y, w, h, c);
            do_fill(x, y, w, h, c, int'($urandom_range(30, 100)), 1'b0);
            checks++;
            if (timed_out || hold_err != 0 || !busy_ok || !ready_after) begin
                errors++;
                $display("FAIL rand[%0d] handshake: got timeout=%0d hold_err=%0d busy_ok=%0d ready_after=%0d, want 0 0 1 1",
                         t, timed_out, hold_err, busy_ok, ready_after);
            end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand[%0d] count: got %0d words, want %0d (x=%0d y=%0d w=%0d h=%0d)",
                         t, obs_q.size(), exp_q.size(), x, y, w, h);
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand[%0d] word %0d: got %h, want %h", t, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int x, y, w, h;
        logic [7:0] c;
        for (int t = 0; t < 6; t++) begin
            rand_cmd(x, y, w, h);
            if (w == 0) w = 1;
            if (h == 0) h = 1;
            c = 8'($urandom);
            model_fill(x, y, w, h, c);
            do_fill(x, y, w, h, c, 100, 1'b0);
            checks++;
            if (n_cycles != exp_q.size() + exp_rows || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL b2b[%0d] cycles: got %0d cycles %0d words, want %0d cycles %0d words",
                         t, n_cycles, obs_q.size(), exp_q.size() + exp_rows, exp_q.size());
            end
        end
    endtask

    task automatic test_busy_ignore();
        int x, y, w, h;
        logic [7:0] c;
        for (int t = 0; t < 4; t++) begin
            rand_cmd(x, y, w, h);
            c = 8'($urandom);
            model_fill(x, y, w, h, c);
            do_fill(x, y, w, h, c, 70, 1'b1);
            checks++;
            if (obs_q.size() != exp_q.size() || !ready_after || timed_out) begin
                errors++;
                $display("FAIL busy_ignore[%0d]: got %0d words ready_after=%0d, want %0d words ready_after=1",
                         t, obs_q.size(), ready_after, exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL busy_ignore[%0d] word %0d: got %h, want %h", t, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int g;
        cmd_x = 10'd0; cmd_y = 10'd0; cmd_width = 10'd12; cmd_height = 10'd1;
        cmd_color = 8'hC3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        g = 0;
        while (!blit_request && g < 10) begin tick(); g++; end
        blit_ack = 1'b1;
        tick();
        blit_ack = 1'b0;
        checks++;
        if (!blit_request || blit_address !== BASE + 26'd4) begin
            errors++;
            $display("FAIL rst_mid_second: got req=%0d addr=%h, want 1 %h", blit_request, blit_address, BASE + 26'd4);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({cmd_ready, busy, done, blit_request} !== 4'b1000 || blit_address !== BASE ||
            blit_wmask !== 4'b0 || blit_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_state: got ready/busy/done/req=%b addr=%h mask=%b data=%h, want 1000 %h 0000 0",
                     {cmd_ready, busy, done, blit_request}, blit_address, blit_wmask, blit_wdata, BASE);
        end
        blit_ack = 1'b1;
        tick();
        blit_ack = 1'b0;
        tick();
        checks++;
        if (blit_address !== BASE || blit_request || busy || !cmd_ready) begin
            errors++;
            $display("FAIL rst_mid_late_ack: got addr=%h req=%0d busy=%0d ready=%0d, want %h 0 0 1",
                     blit_address, blit_request, busy, cmd_ready, BASE);
        end
        model_fill(8, 3, 5, 2, 8'h3C);
        do_fill(8, 3, 5, 2, 8'h3C, 80, 1'b0);
        checks++;
        if (obs_q.size() != exp_q.size() || timed_out) begin
            errors++;
            $display("FAIL rst_mid_restart: got %0d words, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_mid_restart word %0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef BLIT_CLIP_EN
    task automatic test_clip();
        int x, y, w, h;
        do_fill(636, 479, 10, 5, 8'h42, 100, 1'b0);
        checks++;
        if (obs_q.size() != 1 || obs_q[0].addr !== 26'h3fcaffc || obs_q[0].mask !== 4'b1111) begin
            errors++;
            $display("FAIL s5_clip: got %0d words addr=%h mask=%b, want 1 word 3fcaffc 1111", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].addr : 26'h0, (obs_q.size() > 0) ? obs_q[0].mask : 4'h0);
        end
        do_fill(700, 20, 8, 2, 8'h42, 100, 1'b0);
        checks++;
        if (obs_q.size() != 0 || n_cycles != 1 || !ready_after) begin
            errors++;
            $display("FAIL clip_offscreen: got %0d words cycles=%0d, want 0 words 1 cycle", obs_q.size(), n_cycles);
        end
        for (int t = 0; t < 6; t++) begin
            x = int'($urandom_range(600, 700));
            y = int'($urandom_range(470, 500));
            w = int'($urandom_range(1, 60));
            h = int'($urandom_range(1, 15));
            model_fill(x, y, w, h, 8'h99);
            do_fill(x, y, w, h, 8'h99, 60, 1'b0);
            checks++;
            if (obs_q.size() != exp_q.size() || timed_out) begin
                errors++;
                $display("FAIL clip_rand[%0d]: got %0d words, want %0d", t, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL clip_rand[%0d] word %0d: got %h, want %h", t, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; blit_ack = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_width = '0; cmd_height = '0; cmd_color = '0;
        test_reset();
        test_scenarios();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
`ifdef BLIT_CLIP_EN
        test_clip();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/blit_fill.md
BLIT_FILL -- requirements
Module: blit_fill

Interface
- REQ-001 Parameter FB_BASE, default 26'h3f80000, byte address of the 640x480 8-bit-per-pixel framebuffer.
- REQ-002 Parameter FB_STRIDE, default 640, bytes per framebuffer row.
- REQ-003 clock  input  1  100MHz system clock; all logic on its rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 cmd_valid  input  1  fill command present.
- REQ-006 cmd_ready  output  1  block can accept a command; high only in IDLE.
- REQ-007 cmd_x, cmd_y  input  10 each  top-left pixel of the rectangle.
- REQ-008 cmd_width, cmd_height  input  10 each  rectangle size in pixels.
- REQ-009 cmd_color  input  8  palette index to write.
- REQ-010 busy  output  1  high from command accept until done.
- REQ-011 done  output  1  one-cycle pulse when the last word is acknowledged, or when an empty command is retired.
- REQ-012 blit_request  output  1  write request to the SDRAM arbiter.
- REQ-013 blit_address  output  26  word-aligned byte address; bits [1:0] always 0.
- REQ-014 blit_wdata  output  32  cmd_color replicated into all four bytes.
- REQ-015 blit_wmask  output  4  byte enables; bit n enables byte n, which is pixel address[1:0]==n.
- REQ-016 blit_ack  input  1  one-cycle pulse: the current word has been accepted by the arbiter.

Function
- REQ-017 States: IDLE, SETUP, WRITE, NEXT_ROW, DONE.
- REQ-018 IDLE: when cmd_valid && cmd_ready, latch all cmd_* fields and go to SETUP.
- REQ-019 SETUP (one cycle): compute clipped x_end, y_end and the row start address FB_BASE + y*FB_STRIDE + x.
- REQ-020 y*640 is computed as (y<<9)+(y<<7) at 26-bit width with no truncation.
- REQ-021 SETUP goes to DONE with zero writes when the clipped width or height is 0.
- REQ-022 SETUP otherwise goes to WRITE with blit_request=1.
- REQ-023 WRITE: blit_request, blit_address, blit_wdata and blit_wmask are held stable until blit_ack.
- REQ-024 Byte mask: the first word of a row enables bytes from x[1:0] up to 3.
- REQ-025 Byte mask: the last word of a row enables bytes 0 up to x_end[1:0].
- REQ-026 Byte mask: a row that starts and ends in one word gets the intersection of the first- and last-word masks.
- REQ-027 Byte mask: interior words use mask 4'b1111.
- REQ-028 On blit_ack, if the word is not the row's last, the next cycle presents address+4 (pipelined back-to-back, no idle cycle).
- REQ-029 On blit_ack of a row's last word: if more rows remain, go to NEXT_ROW with request low for one cycle; else go to DONE with request low.
- REQ-030 NEXT_ROW: row address += FB_STRIDE, y += 1, return to WRITE.
- REQ-031 DONE: pulse done for one cycle and return to IDLE; cmd_ready is high the following cycle.
- REQ-032 blit_ack while blit_request=0 is ignored.
- REQ-033 cmd_valid while busy is ignored; no queuing.
- REQ-034 Word count per row = ((x+w-1)>>2) - (x>>2) + 1.
- REQ-035 Total cycles for a fill is at least words + rows + 2.

Reset
- REQ-036 reset, including mid-operation, forces IDLE next cycle with blit_request=0, busy=0, done=0, cmd_ready=1, blit_address=FB_BASE, blit_wmask=0, blit_wdata=0.
- REQ-037 Any word in flight is abandoned and a later blit_ack is ignored.

Configuration
- REQ-038 Macro BLIT_CLIP_EN defined: x_end = min(x+w, 640)-1 and y_end = min(y+h, 480)-1.
- REQ-039 BLIT_CLIP_EN defined: a command with x>=640 or y>=480 is retired as empty, with zero writes and a done pulse.
- REQ-040 BLIT_CLIP_EN undefined: no clipping, x_end = x+w-1 and y_end = y+h-1 used unmodified; the caller guarantees bounds.

Verification
- REQ-041 Scenario 1: x=0,y=0,w=4,h=1,color=8'h5A -> one write, addr 26'h3f80000, wdata 32'h5A5A5A5A, mask 4'b1111, then done.
- REQ-042 Scenario 2: x=5,y=2,w=2,h=1 -> one write, addr 26'h3f80504, mask 4'b0110.
- REQ-043 Scenario 3: x=3,y=1,w=6,h=2, ack every cycle -> per row masks 1000, 1111, 0001; addrs 3f80280/284/288 then 3f80500/504/508; done after the 6th ack.
- REQ-044 Scenario 4: w=0 -> no blit_request; done one cycle after SETUP.
- REQ-045 Scenario 5 (BLIT_CLIP_EN): x=636,y=479,w=10,h=5 -> exactly one write, addr 26'h3fcaffc, mask 4'b1111.
- REQ-046 Scenario 6: reset asserted during the 2nd word of a 3-word row -> blit_request=0 next cycle; a later ack produces no address change; a new command then starts cleanly.
